// File: rtl/exception_ctrl.sv
// MEM-stage exception encoder: prioritises fault flags and interrupts into one CP0 code,
// then flushes the pipeline and holds a redirect PC until fetch accepts it.
module exception_ctrl #(
    parameter logic [31:0] BEV_BASE = 32'hBFC00200,
    parameter logic [31:0] GEN_OFF  = 32'h00000180,
    parameter int unsigned SYNC_STG = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        valid_m,
    input  logic        stall_m,
    input  logic [31:0] pc_m,
    input  logic        in_ds_m,
    input  logic [31:0] mem_addr_m,
    input  logic [13:0] exc_flags_m,
    input  logic        eret_m,
    input  logic [31:0] status_i,
    input  logic [31:0] cause_i,
    input  logic [31:0] epc_i,
    input  logic [31:0] ebase_i,
    input  logic [5:0]  int_i,
    input  logic        redirect_rdy_i,
    output logic [31:0] excepttype_o,
    output logic [31:0] cur_pc_o,
    output logic        in_ds_o,
    output logic [31:0] bad_addr_o,
    output logic [5:0]  int_sync_o,
    output logic        flush_o,
    output logic        redirect_vld_o,
    output logic [31:0] redirect_pc_o
);

    localparam int unsigned FAdelIf  = 13;
    localparam int unsigned FItlbRef = 12;
    localparam int unsigned FItlbInv = 11;
    localparam int unsigned FRi      = 10;
    localparam int unsigned FCpu     = 9;
    localparam int unsigned FSys     = 8;
    localparam int unsigned FBrk     = 7;
    localparam int unsigned FOv      = 6;
    localparam int unsigned FTrap    = 5;
    localparam int unsigned FAdelD   = 4;
    localparam int unsigned FAdesD   = 3;
    localparam int unsigned FDtlbRef = 2;
    localparam int unsigned FDtlbInv = 1;
    localparam int unsigned FTlbMod  = 0;

    typedef enum logic [1:0] {BadNone, BadPc, BadMem} bad_sel_e;

    typedef enum logic [0:0] {StIdle, StRedirect} state_e;

    state_e      state_q, state_d;
    logic [5:0]  sync_q [SYNC_STG];
    logic [31:0] redirect_pc_q, redirect_pc_d;
    logic [4:0]  code;
    bad_sel_e    bad_sel;
    logic        int_pend;
    logic        commit;
    logic [31:0] base;

    // Interrupt synchroniser chain
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < int'(SYNC_STG); i++) sync_q[i] <= '0;
        end else begin
            sync_q[0] <= int_i;
            for (int i = 1; i < int'(SYNC_STG); i++) sync_q[i] <= sync_q[i-1];
        end
    end

    assign int_sync_o = sync_q[SYNC_STG-1];

    assign int_pend = (|({int_sync_o, cause_i[9:8]} & status_i[15:8])) & status_i[0] &
                      ~status_i[1] & ~status_i[2];

    always_comb begin
        code    = 5'h00;
        bad_sel = BadNone;
        if (int_pend)                      code = 5'h01;
        else if (exc_flags_m[FAdelIf])  begin code = 5'h04; bad_sel = BadPc;  end
        else if (exc_flags_m[FItlbRef]) begin code = 5'h10; bad_sel = BadPc;  end
        else if (exc_flags_m[FItlbInv]) begin code = 5'h11; bad_sel = BadPc;  end
        else if (exc_flags_m[FRi])         code = 5'h0a;
        else if (exc_flags_m[FCpu])        code = 5'h0b;
        else if (exc_flags_m[FSys])        code = 5'h08;
        else if (exc_flags_m[FBrk])        code = 5'h09;
        else if (exc_flags_m[FOv])         code = 5'h0c;
        else if (exc_flags_m[FTrap])       code = 5'h0d;
        else if (exc_flags_m[FAdelD])   begin code = 5'h04; bad_sel = BadMem; end
        else if (exc_flags_m[FAdesD])   begin code = 5'h05; bad_sel = BadMem; end
        else if (exc_flags_m[FDtlbRef]) begin code = 5'h12; bad_sel = BadMem; end
        else if (exc_flags_m[FDtlbInv]) begin code = 5'h13; bad_sel = BadMem; end
        else if (exc_flags_m[FTlbMod])  begin code = 5'h14; bad_sel = BadMem; end
        else if (eret_m)                   code = 5'h0e;
    end

    assign commit = ~rst & (state_q == StIdle) & valid_m & ~stall_m & (code != 5'h00);

    assign base = status_i[22] ? BEV_BASE : {ebase_i[31:12], 12'h000};

    // TLB refills get the dedicated vector only when not already at exception level
    always_comb begin
        redirect_pc_d = redirect_pc_q;
        if (commit) begin
            if (code == 5'h0e)
                redirect_pc_d = epc_i;
            else if ((code == 5'h10 || code == 5'h12) && !status_i[1])
                redirect_pc_d = base;
            else
                redirect_pc_d = base + GEN_OFF;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= StIdle;
            redirect_pc_q <= '0;
        end else begin
            state_q       <= state_d;
            redirect_pc_q <= redirect_pc_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:     if (commit) state_d = StRedirect;
            StRedirect: if (redirect_rdy_i) state_d = StIdle;
            default:    state_d = StIdle;
        endcase
    end

    always_comb begin
        excepttype_o   = '0;
        cur_pc_o       = '0;
        in_ds_o        = 1'b0;
        bad_addr_o     = '0;
        flush_o        = commit || (state_q == StRedirect);
        redirect_vld_o = (state_q == StRedirect);
        redirect_pc_o  = (state_q == StRedirect) ? redirect_pc_q : '0;
        if (commit) begin
            excepttype_o = {27'h0, code};
            cur_pc_o     = pc_m;
            in_ds_o      = in_ds_m;
            unique case (bad_sel)
                BadPc:   bad_addr_o = pc_m;
                BadMem:  bad_addr_o = mem_addr_m;
                default: bad_addr_o = '0;
            endcase
        end
    end

endmodule

// File: tb/tb_exception_ctrl.sv
// Bench for exception_ctrl: vector table through a scoreboard queue plus hand-built
// sequences for stall, interrupt sync, held redirect and reset-in-redirect.
module tb_exception_ctrl;

    typedef struct {
        logic        valid;
        logic        stall;
        logic        in_ds;
        logic        eret;
        logic [13:0] flags;
        logic [31:0] pc;
        logic [31:0] mem;
        logic [31:0] status;
        logic [31:0] ebase;
        logic [31:0] epc;
        logic [31:0] exp_code;
        logic [31:0] exp_bad;
        logic [31:0] exp_tgt;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        valid_m, stall_m, in_ds_m, eret_m, redirect_rdy_i;
    logic [31:0] pc_m, mem_addr_m, status_i, cause_i, epc_i, ebase_i;
    logic [13:0] exc_flags_m;
    logic [5:0]  int_i;
    logic [31:0] excepttype_o, cur_pc_o, bad_addr_o, redirect_pc_o;
    logic        in_ds_o, flush_o, redirect_vld_o;
    logic [5:0]  int_sync_o;

    int   n_total = 0;
    int   n_pass  = 0;
    vec_t sb[$];
    vec_t tbl[$];

    always #5 clk = ~clk;

    exception_ctrl dut (
        .clk            (clk),
        .rst            (rst),
        .valid_m        (valid_m),
        .stall_m        (stall_m),
        .pc_m           (pc_m),
        .in_ds_m        (in_ds_m),
        .mem_addr_m     (mem_addr_m),
        .exc_flags_m    (exc_flags_m),
        .eret_m         (eret_m),
        .status_i       (status_i),
        .cause_i        (cause_i),
        .epc_i          (epc_i),
        .ebase_i        (ebase_i),
        .int_i          (int_i),
        .redirect_rdy_i (redirect_rdy_i),
        .excepttype_o   (excepttype_o),
        .cur_pc_o       (cur_pc_o),
        .in_ds_o        (in_ds_o),
        .bad_addr_o     (bad_addr_o),
        .int_sync_o     (int_sync_o),
        .flush_o        (flush_o),
        .redirect_vld_o (redirect_vld_o),
        .redirect_pc_o  (redirect_pc_o)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %08h expected %08h", name, act, exp);
    endtask

    function automatic vec_t mk(input logic [13:0] flags, input logic eret, input logic ds,
                                input logic [31:0] pc, input logic [31:0] mem,
                                input logic [31:0] status, input logic [31:0] ebase,
                                input logic [31:0] epc, input logic [31:0] code,
                                input logic [31:0] bad, input logic [31:0] tgt);
        vec_t v;
        v.valid = 1'b1; v.stall = 1'b0; v.in_ds = ds; v.eret = eret; v.flags = flags;
        v.pc = pc; v.mem = mem; v.status = status; v.ebase = ebase; v.epc = epc;
        v.exp_code = code; v.exp_bad = bad; v.exp_tgt = tgt;
        return v;
    endfunction

    task automatic idle_inputs();
        valid_m = 1'b0; stall_m = 1'b0; in_ds_m = 1'b0; eret_m = 1'b0; exc_flags_m = '0;
        redirect_rdy_i = 1'b0;
    endtask

    // Drive one MEM-stage instruction just after the edge and queue its expectation
    task automatic drive(input vec_t v);
        @(posedge clk); #1;
        valid_m = v.valid; stall_m = v.stall; in_ds_m = v.in_ds; eret_m = v.eret;
        exc_flags_m = v.flags; pc_m = v.pc; mem_addr_m = v.mem; status_i = v.status;
        ebase_i = v.ebase; epc_i = v.epc; redirect_rdy_i = 1'b0;
        sb.push_back(v);
    endtask

    task automatic sample(input string tag, output vec_t e);
        logic hit;
        @(negedge clk);
        e = sb.pop_front();
        hit = (e.exp_code != 0);
        chk({tag, ".code"},  excepttype_o, e.exp_code);
        chk({tag, ".pc"},    cur_pc_o, hit ? e.pc : 32'h0);
        chk({tag, ".bad"},   bad_addr_o, e.exp_bad);
        chk({tag, ".ds"},    {31'h0, in_ds_o}, {31'h0, hit & e.in_ds});
        chk({tag, ".flush"}, {31'h0, flush_o}, {31'h0, hit});
    endtask

    // One REDIRECT cycle with rdy as given; checks held vector and flush
    task automatic redir_cycle(input string tag, input logic rdy, input logic [31:0] tgt);
        @(posedge clk); #1;
        idle_inputs();
        redirect_rdy_i = rdy;
        @(negedge clk);
        chk({tag, ".vld"},   {31'h0, redirect_vld_o}, 32'h1);
        chk({tag, ".rpc"},   redirect_pc_o, tgt);
        chk({tag, ".rflush"}, {31'h0, flush_o}, 32'h1);
    endtask

    task automatic back_idle(input string tag);
        @(posedge clk); #1;
        idle_inputs();
        @(negedge clk);
        chk({tag, ".vld0"},   {31'h0, redirect_vld_o}, 32'h0);
        chk({tag, ".flush0"}, {31'h0, flush_o}, 32'h0);
    endtask

    initial begin
        vec_t e;
        vec_t v;
        idle_inputs();
        rst = 1'b1; pc_m = '0; mem_addr_m = '0; status_i = '0; cause_i = '0;
        epc_i = '0; ebase_i = 32'h8000_0000; int_i = '0;

        tbl.push_back(mk(14'h0500, 0, 0, 32'h8000_1000, 32'h0, 32'h0, 32'h8000_0000, 32'h0,
                         32'h0a, 32'h0, 32'h8000_0180));
        tbl.push_back(mk(14'h0004, 0, 0, 32'h8000_1004, 32'h0040_3004, 32'h0, 32'h8000_0000,
                         32'h0, 32'h12, 32'h0040_3004, 32'h8000_0000));
        tbl.push_back(mk(14'h0004, 0, 0, 32'h8000_1008, 32'h0040_3004, 32'h2, 32'h8000_0000,
                         32'h0, 32'h12, 32'h0040_3004, 32'h8000_0180));
        tbl.push_back(mk(14'h3000, 0, 0, 32'h8000_4000, 32'h1234, 32'h0, 32'h8000_0000, 32'h0,
                         32'h04, 32'h8000_4000, 32'h8000_0180));
        tbl.push_back(mk(14'h1000, 0, 0, 32'h0040_0010, 32'h0, 32'h0, 32'h9000_0abc, 32'h0,
                         32'h10, 32'h0040_0010, 32'h9000_0000));
        tbl.push_back(mk(14'h0800, 0, 0, 32'h0040_0020, 32'h0, 32'h0, 32'h8000_0000, 32'h0,
                         32'h11, 32'h0040_0020, 32'h8000_0180));
        tbl.push_back(mk(14'h0001, 0, 0, 32'h8000_0100, 32'h1000_0008, 32'h0, 32'h8000_0000,
                         32'h0, 32'h14, 32'h1000_0008, 32'h8000_0180));
        tbl.push_back(mk(14'h000a, 0, 0, 32'h8000_0104, 32'h1000_0003, 32'h0, 32'h8000_0000,
                         32'h0, 32'h05, 32'h1000_0003, 32'h8000_0180));
        tbl.push_back(mk(14'h0002, 0, 0, 32'h8000_0108, 32'h2000_0000, 32'h0, 32'h8000_0000,
                         32'h0, 32'h13, 32'h2000_0000, 32'h8000_0180));
        tbl.push_back(mk(14'h0010, 0, 0, 32'h8000_010c, 32'h2000_0001, 32'h0, 32'h8000_0000,
                         32'h0, 32'h04, 32'h2000_0001, 32'h8000_0180));
        tbl.push_back(mk(14'h0060, 0, 0, 32'h8000_0110, 32'h0, 32'h0, 32'h8000_0000, 32'h0,
                         32'h0c, 32'h0, 32'h8000_0180));
        tbl.push_back(mk(14'h00c0, 0, 0, 32'h8000_0114, 32'h0, 32'h0, 32'h8000_0000, 32'h0,
                         32'h09, 32'h0, 32'h8000_0180));
        tbl.push_back(mk(14'h0200, 0, 0, 32'h8000_0118, 32'h0, 32'h0, 32'h8000_0000, 32'h0,
                         32'h0b, 32'h0, 32'h8000_0180));
        tbl.push_back(mk(14'h0100, 0, 1, 32'h8000_011c, 32'h0, 32'h0040_0000, 32'h8000_0000,
                         32'h0, 32'h08, 32'h0, 32'hBFC0_0380));
        tbl.push_back(mk(14'h0000, 1, 0, 32'h8000_0120, 32'h0, 32'h0, 32'h8000_0000,
                         32'h8000_2004, 32'h0e, 32'h0, 32'h8000_2004));
        tbl.push_back(mk(14'h0020, 1, 0, 32'h8000_0124, 32'h0, 32'h0, 32'h8000_0000,
                         32'h8000_2004, 32'h0d, 32'h0, 32'h8000_0180));
        tbl.push_back(mk(14'h0000, 0, 0, 32'h8000_0128, 32'h0, 32'h0, 32'h8000_0000, 32'h0,
                         32'h00, 32'h0, 32'h0));
        v = mk(14'h0400, 0, 0, 32'h8000_012c, 32'h0, 32'h0, 32'h8000_0000, 32'h0,
               32'h00, 32'h0, 32'h0);
        v.valid = 1'b0;
        tbl.push_back(v);

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst.code", excepttype_o, 32'h0);
        chk("rst.flush", {31'h0, flush_o}, 32'h0);
        chk("rst.vld", {31'h0, redirect_vld_o}, 32'h0);
        chk("rst.rpc", redirect_pc_o, 32'h0);
        chk("rst.sync", {26'h0, int_sync_o}, 32'h0);
        @(posedge clk); #1;
        rst = 1'b0;

        foreach (tbl[i]) begin
            drive(tbl[i]);
            sample($sformatf("vec%0d", i), e);
            if (e.exp_code != 0) begin
                redir_cycle($sformatf("vec%0d", i), 1'b1, e.exp_tgt);
                back_idle($sformatf("vec%0d", i));
            end
        end

        // Stall masks the commit, then release; BEV vector
        v = mk(14'h2000, 0, 0, 32'h8000_7000, 32'h0, 32'h0040_0000, 32'h8000_0000, 32'h0,
               32'h00, 32'h0, 32'h0);
        v.stall = 1'b1;
        for (int k = 0; k < 2; k++) begin
            drive(v);
            sample($sformatf("stall%0d", k), e);
        end
        v.stall = 1'b0; v.exp_code = 32'h04; v.exp_bad = 32'h8000_7000;
        drive(v);
        sample("stall_rel", e);
        redir_cycle("stall_rel", 1'b1, 32'hBFC0_0380);
        back_idle("stall_rel");

        // ERET with fetch not ready for 3 cycles; younger exceptions ignored meanwhile
        drive(mk(14'h0000, 1, 0, 32'h8000_0200, 32'h0, 32'h0, 32'h8000_0000, 32'h8000_2004,
                 32'h0e, 32'h0, 32'h0));
        sample("eret", e);
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1;
            idle_inputs();
            valid_m = 1'b1; exc_flags_m = 14'h0400; epc_i = 32'h1111_1111;
            @(negedge clk);
            chk($sformatf("eret_hold%0d.vld", k), {31'h0, redirect_vld_o}, 32'h1);
            chk($sformatf("eret_hold%0d.rpc", k), redirect_pc_o, 32'h8000_2004);
            chk($sformatf("eret_hold%0d.flush", k), {31'h0, flush_o}, 32'h1);
            chk($sformatf("eret_hold%0d.code", k), excepttype_o, 32'h0);
        end
        redir_cycle("eret_acc", 1'b1, 32'h8000_2004);
        back_idle("eret_acc");

        // Interrupt: visible on int_sync_o exactly two edges after the rise, beats ov
        @(posedge clk); #1;
        idle_inputs();
        status_i = 32'h0000_0401; int_i = 6'h01;
        @(negedge clk);
        chk("int.sync_t0", {26'h0, int_sync_o}, 32'h0);
        @(negedge clk);
        chk("int.sync_t1", {26'h0, int_sync_o}, 32'h0);
        chk("int.code_t1", excepttype_o, 32'h0);
        drive(mk(14'h0040, 0, 0, 32'h8000_0300, 32'h0, 32'h0000_0401, 32'h8000_0000, 32'h0,
                 32'h01, 32'h0, 32'h0));
        chk("int.sync_t2", {26'h0, int_sync_o}, 32'h1);
        sample("int", e);
        int_i = 6'h00;
        redir_cycle("int", 1'b1, 32'h8000_0180);
        back_idle("int");
        repeat (3) @(posedge clk);

        // Reset while in REDIRECT
        drive(mk(14'h0400, 0, 0, 32'h8000_0400, 32'h0, 32'h0, 32'h8000_0000, 32'h0,
                 32'h0a, 32'h0, 32'h0));
        sample("prerst", e);
        @(posedge clk); #1;
        idle_inputs();
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("rstr.vld", {31'h0, redirect_vld_o}, 32'h0);
        chk("rstr.flush", {31'h0, flush_o}, 32'h0);
        chk("rstr.code", excepttype_o, 32'h0);
        drive(mk(14'h0100, 0, 0, 32'h8000_0500, 32'h0, 32'h0, 32'h8000_0000, 32'h0,
                 32'h08, 32'h0, 32'h0));
        sample("postrst", e);
        redir_cycle("postrst", 1'b1, 32'h8000_0180);
        back_idle("postrst");

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
